// File: rtl/bp_pkg.sv
// Shared types and constants for the branch predictor.
// Holds the prediction-mode codes, the table entry layout and the counter reset value.
package bp_pkg;

   localparam int BP_STATIC  = 0;
   localparam int BP_ONEBIT  = 1;
   localparam int BP_COUNTER = 2;

   // Entry fields are sized for the widest legal geometry (RV32, at least 4 entries,
   // 3-bit counters). Narrower configurations zero-extend into them.
   localparam int BP_XLEN_MAX = 32;
   localparam int BP_TAG_MAX  = BP_XLEN_MAX - 4;
   localparam int BP_CNT_MAX  = 3;

   typedef struct packed {
      logic                   valid;
      logic [BP_TAG_MAX-1:0]  tag;
      logic [BP_XLEN_MAX-1:0] target;
      logic [BP_CNT_MAX-1:0]  cnt;
   } bp_entry_t;

   // Weakly not-taken start value.
   function automatic int bp_init(input int cnt_w);
      return (cnt_w <= 1) ? 0 : (1 << (cnt_w - 1)) - 1;
   endfunction

endpackage

// File: rtl/bp_bht_btb_if.sv
// Fetch-lookup / ID-resolve bundle between the pipeline and the branch predictor.
// master = pipeline (drives PCs and resolution), slave = predictor (drives predictions).
interface bp_bht_btb_if #(
   parameter int XLEN   = 32,
   parameter int PERF_W = 16
);
   logic [XLEN-1:0]   if_pc;
   logic              pred_taken;
   logic [XLEN-1:0]   pred_target;
   logic              id_valid;
   logic              stall;
   logic [XLEN-1:0]   id_pc;
   logic              id_is_branch;
   logic              id_is_jump;
   logic              id_taken;
   logic [XLEN-1:0]   id_target;
   logic              id_pred_taken;
   logic [XLEN-1:0]   id_pred_target;
   logic              mispredict;
   logic [XLEN-1:0]   redirect_pc;
   logic [PERF_W-1:0] perf_branches;
   logic [PERF_W-1:0] perf_mispredicts;

   modport master (
      output if_pc, id_valid, stall, id_pc, id_is_branch, id_is_jump,
             id_taken, id_target, id_pred_taken, id_pred_target,
      input  pred_taken, pred_target, mispredict, redirect_pc,
             perf_branches, perf_mispredicts
   );

   modport slave (
      input  if_pc, id_valid, stall, id_pc, id_is_branch, id_is_jump,
             id_taken, id_target, id_pred_taken, id_pred_target,
      output pred_taken, pred_target, mispredict, redirect_pc,
             perf_branches, perf_mispredicts
   );
endinterface

// File: rtl/bp_sat_counter.sv
// Saturating up/down next-state logic for one prediction counter.
// Ports: i_cnt current value, i_up direction, o_cnt next value (clamped to 0 .. 2^CNT_W-1).
module bp_sat_counter #(
   parameter int W     = 3,
   parameter int CNT_W = 2
) (
   input  logic [W-1:0] i_cnt,
   input  logic         i_up,
   output logic [W-1:0] o_cnt
);

   localparam logic [W-1:0] MAXV = W'((1 << CNT_W) - 1);

   always_comb begin
      o_cnt = i_cnt;
      if (i_up) begin
         if (i_cnt < MAXV) o_cnt = i_cnt + W'(1);
      end else begin
         if (i_cnt != '0) o_cnt = i_cnt - W'(1);
      end
   end

endmodule

// File: rtl/bp_bht_btb.sv
// Direct-mapped BHT/BTB: zero-latency fetch prediction, ID-stage training and mispredict redirect.
// Ports: clk, rst_n (async active-low), bp (slave side of bp_bht_btb_if: lookup, resolve, perf).
module bp_bht_btb
   import bp_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int ENTRIES   = 64,
   parameter int CNT_W     = 2,
   parameter int PRED_MODE = 2,
   parameter int PERF_W    = 16
) (
   input logic          clk,
   input logic          rst_n,
   bp_bht_btb_if.slave  bp
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int INIT  = bp_init(CNT_W);

   localparam logic [BP_CNT_MAX-1:0] C_INIT  = BP_CNT_MAX'(INIT);
   localparam logic [BP_CNT_MAX-1:0] C_ALLOC = BP_CNT_MAX'(INIT + 1);
   localparam logic [BP_CNT_MAX-1:0] C_MAX   = BP_CNT_MAX'((1 << CNT_W) - 1);
   localparam logic [BP_CNT_MAX-1:0] C_THR   = BP_CNT_MAX'(1 << (CNT_W - 1));

   localparam bp_entry_t C_RST = '{
      valid:  1'b0,
      tag:    '0,
      target: '0,
      cnt:    C_INIT
   };

   bp_entry_t r_tbl [ENTRIES];

   logic [PERF_W-1:0] r_perf_br;
   logic [PERF_W-1:0] r_perf_mis;

   logic [IDX_W-1:0]      w_if_idx;
   logic [IDX_W-1:0]      w_id_idx;
   logic [BP_TAG_MAX-1:0] w_if_tag;
   logic [BP_TAG_MAX-1:0] w_id_tag;
   bp_entry_t             w_if_ent;
   bp_entry_t             w_id_ent;
   logic                  w_if_hit;
   logic                  w_id_hit;
   logic                  w_pred;
   logic                  w_res;
   logic                  w_mis;
   logic                  w_we;
   bp_entry_t             w_nxt;
   logic [BP_CNT_MAX-1:0] w_sat;

   // Counter MSB in counter mode reduces to a threshold compare on the stored value.
   function automatic logic f_pbit(input logic [BP_CNT_MAX-1:0] c);
      if (PRED_MODE == BP_COUNTER) return c >= C_THR;
      else if (PRED_MODE == BP_ONEBIT) return c[0];
      else return 1'b0;
   endfunction

   assign w_if_idx = bp.if_pc[IDX_W+1:2];
   assign w_id_idx = bp.id_pc[IDX_W+1:2];
   assign w_if_tag = BP_TAG_MAX'(bp.if_pc[XLEN-1:IDX_W+2]);
   assign w_id_tag = BP_TAG_MAX'(bp.id_pc[XLEN-1:IDX_W+2]);
   assign w_if_ent = r_tbl[w_if_idx];
   assign w_id_ent = r_tbl[w_id_idx];

   assign w_if_hit = w_if_ent.valid && (w_if_ent.tag == w_if_tag);
   assign w_id_hit = w_id_ent.valid && (w_id_ent.tag == w_id_tag);
   assign w_pred   = w_if_hit && f_pbit(w_if_ent.cnt);

   assign bp.pred_taken  = w_pred;
   assign bp.pred_target = w_pred ? w_if_ent.target[XLEN-1:0] : '0;

   assign w_res = bp.id_valid && !bp.stall &&
                  (bp.id_is_branch || bp.id_is_jump);

   assign w_mis = w_res &&
                  ((bp.id_taken != bp.id_pred_taken) ||
                   (bp.id_taken && (bp.id_target != bp.id_pred_target)));

   assign bp.mispredict  = w_mis;
   assign bp.redirect_pc = !w_mis     ? '0 :
                           bp.id_taken ? bp.id_target :
                                         bp.id_pc + XLEN'(4);

   assign bp.perf_branches    = r_perf_br;
   assign bp.perf_mispredicts = r_perf_mis;

   bp_sat_counter #(
      .W     (BP_CNT_MAX),
      .CNT_W (CNT_W)
   ) u_cnt (
      .i_cnt (w_id_ent.cnt),
      .i_up  (bp.id_taken),
      .o_cnt (w_sat)
   );

   // A not-taken outcome on a miss leaves the entry alone.
   always_comb begin
      w_nxt = w_id_ent;
      w_we  = 1'b0;
      if (w_res && (PRED_MODE != BP_STATIC)) begin
         if (bp.id_taken) begin
            w_we         = 1'b1;
            w_nxt.valid  = 1'b1;
            w_nxt.tag    = w_id_tag;
            w_nxt.target = BP_XLEN_MAX'(bp.id_target);
         end
         if (w_id_hit || bp.id_taken) begin
            w_we = 1'b1;
            if (bp.id_is_jump) w_nxt.cnt = C_MAX;
            else if (!w_id_hit) w_nxt.cnt = C_ALLOC;
            else w_nxt.cnt = w_sat;
            if (PRED_MODE == BP_ONEBIT) w_nxt.cnt[0] = bp.id_taken;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) r_tbl[i] <= C_RST;
         r_perf_br  <= '0;
         r_perf_mis <= '0;
      end else begin
         if (w_we) r_tbl[w_id_idx] <= w_nxt;
         if (w_res) begin
            if (r_perf_br != '1) r_perf_br <= r_perf_br + PERF_W'(1);
            if (w_mis && (r_perf_mis != '1))
               r_perf_mis <= r_perf_mis + PERF_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_bp_bht_btb.sv
// Self-checking bench for bp_bht_btb (counter mode, 2-bit counters, 64 entries).
// Directed scenarios followed by randomized traffic against an array-based reference model.
module tb_bp_bht_btb;

   localparam int XLEN    = 32;
   localparam int ENTRIES = 64;
   localparam int CNT_W   = 2;
   localparam int PERF_W  = 16;
   localparam int CMAX    = 3;
   localparam int THR     = 2;
   localparam int INIT    = 1;
   localparam int PMAX    = 65535;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   bp_bht_btb_if #(.XLEN(XLEN), .PERF_W(PERF_W)) bus ();

   bp_bht_btb #(
      .XLEN      (XLEN),
      .ENTRIES   (ENTRIES),
      .CNT_W     (CNT_W),
      .PRED_MODE (2),
      .PERF_W    (PERF_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bp    (bus)
   );

   int n_pass = 0;
   int n_chk  = 0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Reference model: plain arrays indexed by table slot.
   bit          m_v   [ENTRIES];
   int unsigned m_tag [ENTRIES];
   logic [31:0] m_tgt [ENTRIES];
   int          m_cnt [ENTRIES];
   int          m_pb;
   int          m_pm;

   function automatic int idx_of(input logic [31:0] pc);
      return int'(pc / 4) % ENTRIES;
   endfunction

   function automatic int unsigned tag_of(input logic [31:0] pc);
      return pc / (4 * ENTRIES);
   endfunction

   function automatic bit m_hit(input logic [31:0] pc);
      return m_v[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
   endfunction

   function automatic bit m_pred(input logic [31:0] pc);
      return m_hit(pc) && (m_cnt[idx_of(pc)] >= THR);
   endfunction

   function automatic logic [31:0] m_ptgt(input logic [31:0] pc);
      return m_pred(pc) ? m_tgt[idx_of(pc)] : 32'h0;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < ENTRIES; i++) begin
         m_v[i]   = 1'b0;
         m_tag[i] = 0;
         m_tgt[i] = 32'h0;
         m_cnt[i] = INIT;
      end
      m_pb = 0;
      m_pm = 0;
   endtask

   task automatic m_train(input logic [31:0] pc, input bit jmp,
                          input bit tk, input logic [31:0] tgt);
      int i;
      bit hit;
      i   = idx_of(pc);
      hit = m_hit(pc);
      if (jmp) m_cnt[i] = CMAX;
      else if (hit) m_cnt[i] = tk ? ((m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX)
                                  : ((m_cnt[i] > 0) ? m_cnt[i] - 1 : 0);
      else if (tk) m_cnt[i] = INIT + 1;
      if (tk) begin
         m_v[i]   = 1'b1;
         m_tag[i] = tag_of(pc);
         m_tgt[i] = tgt;
      end
   endtask

   task automatic idle(input logic [31:0] lpc);
      bus.if_pc          = lpc;
      bus.id_valid       = 1'b0;
      bus.stall          = 1'b0;
      bus.id_pc          = 32'h0;
      bus.id_is_branch   = 1'b0;
      bus.id_is_jump     = 1'b0;
      bus.id_taken       = 1'b0;
      bus.id_target      = 32'h0;
      bus.id_pred_taken  = 1'b0;
      bus.id_pred_target = 32'h0;
   endtask

   task automatic resolve(input logic [31:0] pc, input bit jmp, input bit tk,
                          input logic [31:0] tgt, input bit ptk,
                          input logic [31:0] ptgt, input bit st);
      bus.id_valid       = 1'b1;
      bus.stall          = st;
      bus.id_pc          = pc;
      bus.id_is_branch   = !jmp;
      bus.id_is_jump     = jmp;
      bus.id_taken       = tk;
      bus.id_target      = tgt;
      bus.id_pred_taken  = ptk;
      bus.id_pred_target = ptgt;
   endtask

   // Called just after a falling edge with inputs driven; returns on the next falling edge.
   task automatic cycle();
      bit          res;
      bit          mis;
      logic [31:0] red;
      #1;
      res = bus.id_valid && !bus.stall && (bus.id_is_branch || bus.id_is_jump);
      mis = res && ((bus.id_taken != bus.id_pred_taken) ||
                    (bus.id_taken && (bus.id_target != bus.id_pred_target)));
      red = !mis ? 32'h0 : (bus.id_taken ? bus.id_target : bus.id_pc + 32'd4);
      chk("pred_taken", bus.pred_taken, m_pred(bus.if_pc));
      chk("pred_target", bus.pred_target, m_ptgt(bus.if_pc));
      chk("mispredict", bus.mispredict, mis);
      chk("redirect_pc", bus.redirect_pc, red);
      chk("perf_branches", bus.perf_branches, m_pb);
      chk("perf_mispredicts", bus.perf_mispredicts, m_pm);
      @(posedge clk);
      if (res) begin
         m_train(bus.id_pc, bus.id_is_jump, bus.id_taken, bus.id_target);
         if (m_pb < PMAX) m_pb++;
         if (mis && m_pm < PMAX) m_pm++;
      end
      @(negedge clk);
   endtask

   function automatic logic [31:0] rpc();
      return 32'h1000 + (32'($urandom_range(0, 3)) << 8) +
             (32'($urandom_range(0, 7)) << 2);
   endfunction

   initial begin
      logic [31:0] pc;
      logic [31:0] tgt;
      bit          jmp;
      bit          tk;
      bit          ptk;
      logic [31:0] ptgt;

      idle(32'h40);
      m_reset();
      @(negedge clk);
      #1;
      chk("rst_pred_taken", bus.pred_taken, 0);
      chk("rst_pred_target", bus.pred_target, 0);
      chk("rst_perf_br", bus.perf_branches, 0);
      chk("rst_perf_mis", bus.perf_mispredicts, 0);
      chk("rst_mispredict", bus.mispredict, 0);
      chk("rst_redirect", bus.redirect_pc, 0);
      @(negedge clk);
      rst_n = 1'b1;

      resolve(32'h40, 1'b0, 1'b1, 32'h20, 1'b0, 32'h0, 1'b0);
      #1;
      chk("first_mis", bus.mispredict, 1);
      chk("first_redirect", bus.redirect_pc, 32'h20);
      cycle();
      for (int k = 0; k < 2; k++) begin
         resolve(32'h40, 1'b0, 1'b1, 32'h20, m_pred(32'h40), m_ptgt(32'h40), 1'b0);
         cycle();
      end
      idle(32'h40);
      #1;
      chk("trained_taken", bus.pred_taken, 1);
      chk("trained_target", bus.pred_target, 32'h20);
      cycle();

      resolve(32'h40, 1'b0, 1'b0, 32'h20, 1'b1, 32'h20, 1'b0);
      #1;
      chk("nt_mis", bus.mispredict, 1);
      chk("nt_redirect", bus.redirect_pc, 32'h44);
      cycle();
      idle(32'h40);
      #1;
      chk("nt_still_taken", bus.pred_taken, 1);
      cycle();

      resolve(32'h40, 1'b0, 1'b1, 32'h20, 1'b1, 32'h20, 1'b0);
      cycle();
      idle(32'h140);
      #1;
      chk("alias_taken", bus.pred_taken, 0);
      chk("alias_target", bus.pred_target, 0);
      cycle();

      resolve(32'h40, 1'b0, 1'b0, 32'h20, 1'b1, 32'h20, 1'b1);
      #1;
      chk("stall_mis", bus.mispredict, 0);
      cycle();
      idle(32'h40);
      #1;
      chk("stall_perf_br", bus.perf_branches, 5);
      chk("stall_perf_mis", bus.perf_mispredicts, 2);
      cycle();
      resolve(32'h40, 1'b0, 1'b0, 32'h20, 1'b1, 32'h20, 1'b0);
      cycle();
      idle(32'h40);
      #1;
      chk("stall_no_train", bus.pred_taken, 1);
      cycle();

      resolve(32'h40, 1'b0, 1'b1, 32'h20, 1'b1, 32'h20, 1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      m_reset();
      idle(32'h40);
      #1;
      chk("mid_rst_perf_br", bus.perf_branches, 0);
      chk("mid_rst_pred", bus.pred_taken, 0);
      @(negedge clk);
      rst_n = 1'b1;
      resolve(32'h40, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0);
      cycle();
      idle(32'h40);
      #1;
      chk("realloc_taken", bus.pred_taken, 1);
      chk("realloc_target", bus.pred_target, 32'h80);
      cycle();
      resolve(32'h40, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80, 1'b0);
      cycle();
      idle(32'h40);
      #1;
      chk("realloc_cnt2", bus.pred_taken, 0);
      cycle();

      for (int n = 0; n < 1500; n++) begin
         pc  = rpc();
         tgt = rpc();
         jmp = ($urandom_range(0, 4) == 0);
         tk  = jmp ? 1'b1 : 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 0) begin
            ptk  = m_pred(pc);
            ptgt = m_ptgt(pc);
         end else begin
            ptk  = 1'($urandom_range(0, 1));
            ptgt = rpc();
         end
         resolve(pc, jmp, tk, tgt, ptk, ptgt, ($urandom_range(0, 9) == 0));
         bus.id_valid     = ($urandom_range(0, 9) != 0);
         bus.id_is_branch = !jmp && ($urandom_range(0, 5) != 0);
         bus.if_pc        = rpc();
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
